// File: rtl/uart_rx_oversampled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the oversampled UART receiver.
//               rx_state_t is the receiver FSM state encoding. The defaults
//               give the usual 16x oversampling and 8-bit data.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    localparam int UART_OVERSAMPLING_DEF = 16;
    localparam int UART_DATA_BITS_DEF    = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled_if
// Description : Received-word bus of the oversampled UART receiver.
//               The receiver drives it through the master modport. A consumer
//               reads it through the slave modport and must capture data on
//               the valid pulse, because there is no back-pressure.
//   data       [DATA_BITS] last received word, LSB = first bit on the line
//   valid      1-cycle pulse: data and error flags were just updated
//   frame_err  stop bit was sampled low
//   parity_err parity mismatch (always 0 without parity)
//   busy       receiver is somewhere in a frame (not IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output data,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        input data,
        input valid,
        input frame_err,
        input parity_err,
        input busy
    );
endinterface : uart_rx_oversampled_if
`default_nettype wire

// File: rtl/uart_rx_oversampled_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Two-flop synchroniser for asynchronous inputs. Reset loads
//               RST_VAL into both stages so that an idle-high line does not
//               produce a false edge when reset is released.
//   i_clk      destination clock
//   i_aresetn  synchronous active-low reset
//   i_d        asynchronous input
//   o_q        synchronised output (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  wire              i_clk,
    input  wire              i_aresetn,
    input  wire  [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : bit_sync
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : UART receiver driven by an oversampled baud tick
//               (OVERSAMPLING ticks per bit). The serial line is synchronised.
//               The start bit is confirmed at mid-bit. Data is shifted in
//               LSB-first, parity is checked if enabled, and every completed
//               frame is reported with a single-cycle valid pulse together
//               with framing and parity flags. A line held low after a bad
//               stop bit (break) is reported once and then ignored until the
//               line returns high.
//   i_clk        system clock
//   i_aresetn    synchronous active-low reset
//   i_baud_tick  1-cycle pulse, OVERSAMPLING per bit period
//   i_rx         asynchronous serial line, idle high
//   rx_bus       received-word bus (master side): data, valid, frame_err,
//                parity_err, busy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = UART_OVERSAMPLING_DEF,
    parameter int DATA_BITS    = UART_DATA_BITS_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int TCNT_WIDTH   = $clog2(OVERSAMPLING)
) (
    input  wire                   i_clk,
    input  wire                   i_aresetn,
    input  wire                   i_baud_tick,
    input  wire                   i_rx,
    uart_rx_oversampled_if.master rx_bus
);

    localparam int c_BCNT_WIDTH = $clog2(DATA_BITS + 1);

    // Counter compare points: middle of the start bit, and the last tick of
    // a full bit period. Data, parity and stop bits are all sampled at the
    // last tick of a period measured from the mid start bit, so that they
    // are sampled at their own mid-bit.
    localparam logic [TCNT_WIDTH-1:0]   c_TICK_MID  = TCNT_WIDTH'(OVERSAMPLING / 2 - 1);
    localparam logic [TCNT_WIDTH-1:0]   c_TICK_LAST = TCNT_WIDTH'(OVERSAMPLING - 1);
    localparam logic [c_BCNT_WIDTH-1:0] c_BIT_LAST  = c_BCNT_WIDTH'(DATA_BITS - 1);
    localparam logic                    c_PAR_ODD   = (PARITY_ODD != 0);
    localparam logic                    c_PAR_EN    = (PARITY_EN != 0);

    // ------------------------------------------------------------------
    // Line synchroniser: only the synchronised copy is used below.
    // ------------------------------------------------------------------
    logic w_rx_s;

    bit_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .i_d       (i_rx),
        .o_q       (w_rx_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    rx_state_t               r_state;
    logic [TCNT_WIDTH-1:0]   r_tick_cnt;
    logic [c_BCNT_WIDTH-1:0] r_bit_cnt;
    logic [DATA_BITS-1:0]    r_shreg;
    logic                    r_par_err;
    logic [DATA_BITS-1:0]    r_data;
    logic                    r_valid;
    logic                    r_frame_err;
    logic                    r_parity_err;

    rx_state_t               w_state_nxt;
    logic [TCNT_WIDTH-1:0]   w_tick_cnt_nxt;
    logic [c_BCNT_WIDTH-1:0] w_bit_cnt_nxt;
    logic [DATA_BITS-1:0]    w_shreg_nxt;
    logic                    w_par_err_nxt;
    logic [DATA_BITS-1:0]    w_data_nxt;
    logic                    w_valid_nxt;
    logic                    w_frame_err_nxt;
    logic                    w_parity_err_nxt;

    // Parity of the received data plus the parity bit on the line.
    // Even parity expects an even total, so any odd result is an error;
    // odd parity inverts that.
    logic w_par_calc;
    assign w_par_calc = (^r_shreg) ^ w_rx_s ^ c_PAR_ODD;

    // ------------------------------------------------------------------
    // Next-state / datapath logic. Nothing moves on cycles without a tick,
    // so every branch sits under i_baud_tick.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_tick_cnt_nxt   = r_tick_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shreg_nxt      = r_shreg;
        w_par_err_nxt    = r_par_err;
        w_data_nxt       = r_data;
        w_valid_nxt      = 1'b0;
        w_frame_err_nxt  = r_frame_err;
        w_parity_err_nxt = r_parity_err;

        if (i_baud_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt    = START;
                        w_tick_cnt_nxt = '0;
                    end
                end

                START: begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                        // A line that is high again at mid start bit was
                        // a glitch: drop it silently.
                        w_state_nxt    = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        // Shift right: after DATA_BITS samples the first
                        // bit on the line is in the LSB.
                        w_shreg_nxt    = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_nxt = c_PAR_EN ? PARITY : STOP;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_par_err_nxt  = w_par_calc;
                        w_tick_cnt_nxt = '0;
                        w_state_nxt    = STOP;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_data_nxt       = r_shreg;
                        w_valid_nxt      = 1'b1;
                        w_frame_err_nxt  = ~w_rx_s;
                        w_parity_err_nxt = r_par_err;
                        w_tick_cnt_nxt   = '0;
                        // A low stop bit may be the start of a break; wait
                        // for the line to recover so the break is reported
                        // only once.
                        w_state_nxt      = w_rx_s ? IDLE : BRK_WAIT;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                BRK_WAIT: begin
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end
                end

                default: begin
                    w_state_nxt    = IDLE;
                    w_tick_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_par_err    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_par_err    <= w_par_err_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_bus.data       = r_data;
    assign rx_bus.valid      = r_valid;
    assign rx_bus.frame_err  = r_frame_err;
    assign rx_bus.parity_err = r_parity_err;
    assign rx_bus.busy       = (r_state != IDLE);

endmodule : uart_rx_oversampled
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Self-checking bench for uart_rx_oversampled. Two receivers
//               share the clock, tick and reset: dut_a is 8N1, dut_b is 8E1.
//               Each frame the bench transmits is turned into an expected
//               record (data, flags, start tick) using UART framing rules.
//               A compare process checks both receivers on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 6;
    localparam int B_ODD    = 0;

    logic clk      = 1'b0;
    logic aresetn  = 1'b0;
    logic rx_a     = 1'b1;
    logic rx_b     = 1'b1;
    logic baud_tick;
    int   tdiv     = 0;
    int   tick_idx = 0;
    logic rst_seen = 1'b0;

    int checks = 0;
    int errors = 0;
    int nv[2];

    typedef struct {
        logic [DB-1:0] data;
        logic          fe;
        logic          pe;
        int            t0;
        int            nbits;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [DB-1:0] m_data[2];
    logic          m_fe[2];
    logic          m_pe[2];
    logic          prev_v[2];

    uart_rx_oversampled_if #(.DATA_BITS(DB)) bus_a ();
    uart_rx_oversampled_if #(.DATA_BITS(DB)) bus_b ();

    uart_rx_oversampled #(
        .OVERSAMPLING (OS),
        .DATA_BITS    (DB),
        .PARITY_EN    (0),
        .PARITY_ODD   (0)
    ) dut_a (
        .i_clk       (clk),
        .i_aresetn   (aresetn),
        .i_baud_tick (baud_tick),
        .i_rx        (rx_a),
        .rx_bus      (bus_a)
    );

    uart_rx_oversampled #(
        .OVERSAMPLING (OS),
        .DATA_BITS    (DB),
        .PARITY_EN    (1),
        .PARITY_ODD   (B_ODD)
    ) dut_b (
        .i_clk       (clk),
        .i_aresetn   (aresetn),
        .i_baud_tick (baud_tick),
        .i_rx        (rx_b),
        .rx_bus      (bus_b)
    );

    always #5 clk = ~clk;

    assign baud_tick = (tdiv == 0);

    always @(posedge clk) begin
        tdiv     <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
        if (baud_tick) tick_idx <= tick_idx + 1;
        rst_seen <= aresetn;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Per-cycle comparison of one receiver against the model.
    task automatic cmp(input int idx, input logic v, input logic [DB-1:0] d,
                       input logic fe, input logic pe, input logic busy);
        exp_t e;
        int   lo;
        int   qs;
        if (!rst_seen) begin
            chk("reset_outputs", idx, {19'd0, v, d, fe, pe, busy}, 32'd0);
            m_data[idx] = '0;
            m_fe[idx]   = 1'b0;
            m_pe[idx]   = 1'b0;
            prev_v[idx] = 1'b0;
        end else begin
            if (v) begin
                nv[idx]++;
                chk("valid_back_to_back", idx, {31'd0, prev_v[idx]}, 32'd0);
                qs = (idx == 0) ? q_a.size() : q_b.size();
                if (qs == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid dut%0d actual data=%0h expected no frame", idx, d);
                end else begin
                    e = (idx == 0) ? q_a.pop_front() : q_b.pop_front();
                    chk("data", idx, {24'd0, d}, {24'd0, e.data});
                    chk("frame_err", idx, {31'd0, fe}, {31'd0, e.fe});
                    chk("parity_err", idx, {31'd0, pe}, {31'd0, e.pe});
                    // Valid follows the mid-stop-bit tick: start bit, all
                    // data/parity bits, then half a stop bit after the start
                    // edge, plus up to two ticks of sync/detection slack.
                    lo = e.t0 + (e.nbits + 1) * OS + OS / 2;
                    checks++;
                    if (tick_idx < lo || tick_idx > lo + 2 || tdiv != 1) begin
                        errors++;
                        $display("FAIL latency dut%0d actual tick=%0d phase=%0d expected tick %0d..%0d phase 1",
                                 idx, tick_idx, tdiv, lo, lo + 2);
                    end
                    m_data[idx] = e.data;
                    m_fe[idx]   = e.fe;
                    m_pe[idx]   = e.pe;
                end
            end else begin
                chk("hold", idx, {22'd0, d, fe, pe}, {22'd0, m_data[idx], m_fe[idx], m_pe[idx]});
            end
            prev_v[idx] = v;
        end
    endtask

    always @(negedge clk) begin
        cmp(0, bus_a.valid, bus_a.data, bus_a.frame_err, bus_a.parity_err, bus_a.busy);
        cmp(1, bus_b.valid, bus_b.data, bus_b.frame_err, bus_b.parity_err, bus_b.busy);
    end

    // Returns #1 after the clock edge on which a tick was sampled.
    task automatic wait_tick();
        @(posedge clk);
        while (baud_tick !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic set_rx(input int idx, input logic v);
        if (idx == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Transmit one frame; pbit < 0 means no parity bit. The expected record
    // comes from framing rules: frame error when the stop bit is 0, parity
    // error when data plus parity bit has the wrong total parity.
    task automatic send_frame(input int idx, input logic [DB-1:0] d, input logic stop_v,
                              input int pbit);
        exp_t e;
        logic pb;
        pb      = (pbit > 0);
        e.data  = d;
        e.fe    = ~stop_v;
        e.pe    = (pbit >= 0) ? ((^d) ^ pb ^ (B_ODD != 0)) : 1'b0;
        e.t0    = tick_idx;
        e.nbits = DB + ((pbit >= 0) ? 1 : 0);
        if (idx == 0) q_a.push_back(e);
        else          q_b.push_back(e);
        set_rx(idx, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) begin
            set_rx(idx, d[i]);
            wait_ticks(OS);
        end
        if (pbit >= 0) begin
            set_rx(idx, pb);
            wait_ticks(OS);
        end
        set_rx(idx, stop_v);
        wait_ticks(OS);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] d3c;
        d3c   = 8'h3C;
        nv[0] = 0;
        nv[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 0, {24'd0, bus_a.data}, 32'd0);
        chk("reset_busy", 0, {31'd0, bus_a.busy}, 32'd0);
        chk("reset_valid", 1, {31'd0, bus_b.valid}, 32'd0);
        aresetn = 1'b1;
        wait_tick();

        // 8N1 frame 0x55
        send_frame(0, 8'h55, 1'b1, -1);
        wait_ticks(2 * OS);
        chk("t55_count", 0, nv[0], 1);
        chk("t55_data", 0, {24'd0, bus_a.data}, 32'h55);
        chk("t55_fe", 0, {31'd0, bus_a.frame_err}, 32'd0);
        chk("t55_pe", 0, {31'd0, bus_a.parity_err}, 32'd0);
        chk("t55_busy", 0, {31'd0, bus_a.busy}, 32'd0);

        // Glitch: low for 3 ticks only
        set_rx(0, 1'b0);
        wait_ticks(2);
        chk("glitch_busy_hi", 0, {31'd0, bus_a.busy}, 32'd1);
        wait_ticks(1);
        set_rx(0, 1'b1);
        wait_ticks(2 * OS);
        chk("glitch_count", 0, nv[0], 1);
        chk("glitch_data", 0, {24'd0, bus_a.data}, 32'h55);
        chk("glitch_busy_lo", 0, {31'd0, bus_a.busy}, 32'd0);

        // 0xA3 with stop bit 0, then break for 20 bit times
        send_frame(0, 8'hA3, 1'b0, -1);
        wait_ticks(20 * OS);
        chk("brk_busy", 0, {31'd0, bus_a.busy}, 32'd1);
        chk("brk_count", 0, nv[0], 2);
        set_rx(0, 1'b1);
        wait_ticks(2 * OS);
        chk("brk_data", 0, {24'd0, bus_a.data}, 32'hA3);
        chk("brk_fe", 0, {31'd0, bus_a.frame_err}, 32'd1);
        chk("brk_idle", 0, {31'd0, bus_a.busy}, 32'd0);
        send_frame(0, 8'h12, 1'b1, -1);
        wait_ticks(2 * OS);
        chk("after_brk_count", 0, nv[0], 3);
        chk("after_brk_data", 0, {24'd0, bus_a.data}, 32'h12);
        chk("after_brk_fe", 0, {31'd0, bus_a.frame_err}, 32'd0);

        // Even parity on dut_b: 0x07 has three ones
        send_frame(1, 8'h07, 1'b1, 0);
        wait_ticks(2 * OS);
        chk("par0_count", 1, nv[1], 1);
        chk("par0_pe", 1, {31'd0, bus_b.parity_err}, 32'd1);
        send_frame(1, 8'h07, 1'b1, 1);
        wait_ticks(2 * OS);
        chk("par1_count", 1, nv[1], 2);
        chk("par1_pe", 1, {31'd0, bus_b.parity_err}, 32'd0);
        chk("par1_data", 1, {24'd0, bus_b.data}, 32'h07);

        // Back-to-back frames, single stop bit, no gap
        send_frame(0, 8'h00, 1'b1, -1);
        send_frame(0, 8'hFF, 1'b1, -1);
        send_frame(0, 8'h81, 1'b1, -1);
        wait_ticks(2 * OS);
        chk("b2b_count", 0, nv[0], 6);
        chk("b2b_data", 0, {24'd0, bus_a.data}, 32'h81);
        chk("b2b_flags", 0, {30'd0, bus_a.frame_err, bus_a.parity_err}, 32'd0);

        // Reset during bit 4 of 0x3C; the transmitter abandons the frame
        set_rx(0, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 5; i++) begin
            set_rx(0, d3c[i]);
            wait_ticks((i == 4) ? OS / 2 : OS);
        end
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        chk("rst_mid_data", 0, {24'd0, bus_a.data}, 32'd0);
        chk("rst_mid_busy", 0, {31'd0, bus_a.busy}, 32'd0);
        set_rx(0, 1'b1);
        wait_tick();
        wait_ticks(12 * OS);
        chk("rst_mid_count", 0, nv[0], 6);
        chk("rst_mid_idle", 0, {31'd0, bus_a.busy}, 32'd0);
        send_frame(0, 8'h3C, 1'b1, -1);
        wait_ticks(2 * OS);
        chk("rst_after_count", 0, nv[0], 7);
        chk("rst_after_data", 0, {24'd0, bus_a.data}, 32'h3C);

        chk("pending_a", 0, q_a.size(), 0);
        chk("pending_b", 1, q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_oversampled
`default_nettype wire
